fpu_arith_arbiter: RTL and testbench

//  Shares one FPU_ArithmeticUnit between NUM_REQ requesters, e.g. MicroSequencer_Extended
//  (transcendental microprograms) and the direct-execution path. Round-robin grant,
//  one operation in flight, operands latched at grant, result routed back to the owner.

---
 rtl/fpu_arith_pkg.sv | 19 +
 rtl/fpu_rr_picker.sv | 36 +++
 rtl/fpu_arith_arbiter.sv | 161 ++++++++++++++++
 tb/tb_fpu_arith_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_arith_pkg.sv
// Shared widths, constants and state encoding for the FPU arithmetic-unit arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fpu_arith_pkg;

    localparam int FP80_W = 80;
    localparam int OP_W   = 5;
    localparam int RND_W  = 2;

    // Default quiet NaN returned when the unit never answers.
    localparam logic [FP80_W-1:0] FP80_QNAN = 80'hFFFF_C000_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fpu_rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, searching cyclically.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the winner is consumed.
module fpu_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_vld
);

    int cand;

    // Walk the requesters starting at ptr and stop at the first one asserted.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_vld    = 1'b0;
        cand       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_vld && req[IDX_W'(cand)]) begin
                win_vld                   = 1'b1;
                win_onehot[IDX_W'(cand)]  = 1'b1;
                win_idx                   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fpu_arith_arbiter.sv
// Shares one FPU arithmetic unit between NUM_REQ requesters, round-robin, one op in flight.
// Latency: request seen in IDLE at N -> arith_enable at N+1; arith_done at M -> rsp_done at M+1.
// Backpressure: requesters hold req_valid until rsp_done; optional watchdog via FPU_ARB_TIMEOUT_EN.
module fpu_arith_arbiter
    import fpu_arith_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [OP_W*NUM_REQ-1:0]   req_op,
    input  logic [RND_W*NUM_REQ-1:0]  req_rounding,
    input  logic [FP80_W*NUM_REQ-1:0] req_a,
    input  logic [FP80_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        rsp_done,
    output logic [FP80_W-1:0]         rsp_result,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      arith_enable,
    output logic [OP_W-1:0]           arith_op,
    output logic [RND_W-1:0]          arith_rounding,
    output logic [FP80_W-1:0]         arith_a,
    output logic [FP80_W-1:0]         arith_b,
    input  logic [FP80_W-1:0]         arith_result,
    input  logic                      arith_done,
    output logic                      timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("fpu_arith_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_e         state;
    arb_state_e         state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               wd_expire;

    fpu_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req_valid),
        .ptr        (ptr),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .win_vld    (pick_vld)
    );

`ifdef FPU_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt;

    // Give up only if the unit has not answered in this very cycle.
    assign wd_expire = (state == ST_BUSY) && !arith_done && (wd_cnt == 32'(TIMEOUT_CYCLES));

    // Watchdog: cleared on the way into BUSY, then counts every BUSY cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == ST_IDLE && pick_vld) begin
            wd_cnt <= '0;
        end else if (state == ST_BUSY) begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (wd_expire) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: grant in IDLE, wait for the unit (or watchdog) in BUSY, one RESP cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pick_vld) state_nxt = ST_BUSY;
            ST_BUSY: if (arith_done || wd_expire) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only, so no request reaches enable combinationally.
    always_comb begin
        arith_enable = (state == ST_BUSY);
        busy         = (state == ST_BUSY);
        rsp_done     = '0;
        if (state == ST_RESP) begin
            rsp_done = grant;
        end
    end

    // Datapath: latch the winner's operands, capture the result, advance the pointer after RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant          <= '0;
            owner          <= '0;
            ptr            <= '0;
            arith_op       <= '0;
            arith_rounding <= '0;
            arith_a        <= '0;
            arith_b        <= '0;
            rsp_result     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant          <= pick_onehot;
                        owner          <= pick_idx;
                        arith_op       <= req_op[pick_idx*OP_W +: OP_W];
                        arith_rounding <= req_rounding[pick_idx*RND_W +: RND_W];
                        arith_a        <= req_a[pick_idx*FP80_W +: FP80_W];
                        arith_b        <= req_b[pick_idx*FP80_W +: FP80_W];
                    end
                end
                ST_BUSY: begin
                    if (arith_done) begin
                        rsp_result <= arith_result;
                    end else if (wd_expire) begin
                        rsp_result <= FP80_QNAN;
                    end
                end
                ST_RESP: begin
                    grant <= '0;
                    if (owner == IDX_W'(NUM_REQ - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= owner + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_arith_arbiter.sv
// Bench for fpu_arith_arbiter with a behavioural arithmetic unit and requesters.
// Latency: n/a (testbench).
// Backpressure: requesters hold req_valid until their rsp_done pulse.
module tb_fpu_arith_arbiter;
    import fpu_arith_pkg::*;

    localparam int N  = 3;
    localparam int TO = 16;
    localparam logic [79:0] ONE   = 80'h3FFF_8000_0000_0000_0000;
    localparam logic [79:0] TWO   = 80'h4000_8000_0000_0000_0000;
    localparam logic [79:0] THREE = 80'h4000_C000_0000_0000_0000;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [5*N-1:0]  req_op;
    logic [2*N-1:0]  req_rounding;
    logic [80*N-1:0] req_a;
    logic [80*N-1:0] req_b;
    logic [N-1:0]    rsp_done;
    logic [79:0]     rsp_result;
    logic [N-1:0]    grant;
    logic            busy;
    logic            arith_enable;
    logic [4:0]      arith_op;
    logic [1:0]      arith_rounding;
    logic [79:0]     arith_a;
    logic [79:0]     arith_b;
    logic [79:0]     arith_result = '0;
    logic            arith_done;
    logic            timeout_err;
    logic            stub_done = 1'b0;
    logic            spur_done;

    int n_cmp = 0;
    int n_err = 0;
    int multi_grant = 0;
    int stub_cnt = 0;
    bit stub_fired = 1'b0;
    int stub_delay = 0;
    bit stub_mute = 1'b0;

    logic [4:0]  cur_op [N];
    logic [1:0]  cur_rnd[N];
    logic [79:0] cur_a  [N];
    logic [79:0] cur_b  [N];
    int          rem    [N];
    int          got_q[$];
    int          exp_q[$];
    int          mptr;

    typedef struct {
        int          idx;
        logic [4:0]  op;
        logic [1:0]  rnd;
        logic [79:0] a;
        logic [79:0] b;
        int          dly;
        bit          drop_early;
        logic [79:0] exp;
    } vec_t;

    assign arith_done = stub_done | spur_done;

    fpu_arith_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_rounding(req_rounding), .req_a(req_a), .req_b(req_b),
        .rsp_done(rsp_done), .rsp_result(rsp_result), .grant(grant), .busy(busy),
        .arith_enable(arith_enable), .arith_op(arith_op), .arith_rounding(arith_rounding),
        .arith_a(arith_a), .arith_b(arith_b), .arith_result(arith_result),
        .arith_done(arith_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Behavioural unit: the exact FP80 sum for 1.0+2.0, otherwise a fixed mixing of the operands.
    function automatic logic [79:0] unit_fn(input logic [4:0] op, input logic [1:0] rnd,
                                            input logic [79:0] a, input logic [79:0] b);
        if (op == 5'd0 && a == ONE && b == TWO) return THREE;
        return a ^ {b[38:0], b[79:39]} ^ {op, rnd, 73'd0};
    endfunction

    // Unit stub: answers stub_delay+1 cycles after enable rises, unless muted.
    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (!arith_enable) begin
            stub_cnt   <= 0;
            stub_fired <= 1'b0;
        end else if (!stub_mute && !stub_fired) begin
            if (stub_cnt >= stub_delay) begin
                stub_done    <= 1'b1;
                arith_result <= unit_fn(arith_op, arith_rounding, arith_a, arith_b);
                stub_fired   <= 1'b1;
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    // Grant must never have more than one bit set.
    always @(negedge clk) begin
        if ($countones(grant) > 1) multi_grant <= multi_grant + 1;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish before t=400000");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int owner_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit any_rem();
        for (int i = 0; i < N; i++) if (rem[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_req(input int i, input logic [4:0] op, input logic [1:0] rnd,
                           input logic [79:0] a, input logic [79:0] b);
        req_op[5*i +: 5]        = op;
        req_rounding[2*i +: 2]  = rnd;
        req_a[80*i +: 80]       = a;
        req_b[80*i +: 80]       = b;
        cur_op[i] = op; cur_rnd[i] = rnd; cur_a[i] = a; cur_b[i] = b;
        req_valid[i] = 1'b1;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 5'($urandom), 2'($urandom), 80'({$urandom(), $urandom(), $urandom()}),
                80'({$urandom(), $urandom(), $urandom()}));
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset     = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        stub_mute = 1'b0;
        mptr      = 0;
        @(negedge clk);
    endtask

    // Reference order: repeatedly serve the first requester with work left at or after the pointer.
    task automatic model_order();
        int r[N];
        int p;
        bit found;
        r = rem;
        p = mptr;
        exp_q.delete();
        do begin
            found = 1'b0;
            for (int k = 0; k < N && !found; k++) begin
                int c;
                c = (p + k) % N;
                if (r[c] > 0) begin
                    exp_q.push_back(c);
                    r[c]--;
                    p     = (c + 1) % N;
                    found = 1'b1;
                end
            end
        end while (found);
        mptr = p;
    endtask

    // Act as the requesters: on each rsp_done check the result and issue the owner's next op.
    task automatic run_ops(input int budget);
        int cyc;
        int o;
        cyc = 0;
        got_q.delete();
        while (any_rem() && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (rsp_done != '0) begin
                o = owner_of(rsp_done);
                chk("rsp_onehot", 80'($countones(rsp_done)), 80'd1);
                chk("op_result", rsp_result, unit_fn(cur_op[o], cur_rnd[o], cur_a[o], cur_b[o]));
                got_q.push_back(o);
                rem[o]--;
                if (rem[o] == 0) req_valid[o] = 1'b0;
                else rand_req(o);
                stub_delay = $urandom_range(0, 4);
            end
        end
        chk("ops_done_in_budget", 80'(any_rem()), 80'd0);
        @(negedge clk);
    endtask

    task automatic check_order(input string nm);
        chk({nm, "_len"}, 80'(got_q.size()), 80'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk(nm, (i < got_q.size()) ? 80'(got_q[i]) : '1, 80'(exp_q[i]));
    endtask

    task automatic wait_done(output int k, input int bound);
        k = 0;
        while (rsp_done == '0 && k < bound) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        vec_t vt[6];
        int   k;

        reset = 1'b1; req_valid = '0; req_op = '0; req_rounding = '0;
        req_a = '0; req_b = '0; spur_done = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_grant", 80'(grant), 80'd0);
        chk("rst_busy", 80'(busy), 80'd0);
        chk("rst_enable", 80'(arith_enable), 80'd0);
        chk("rst_rsp_done", 80'(rsp_done), 80'd0);
        chk("rst_result", rsp_result, 80'd0);
        chk("rst_arith_a", arith_a, 80'd0);
        chk("rst_timeout_err", 80'(timeout_err), 80'd0);
        reset = 1'b0;
        @(negedge clk);

        // arith_done outside BUSY is ignored
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("spur_busy", 80'(busy), 80'd0);
        @(negedge clk);
        chk("spur_rsp_done", 80'(rsp_done), 80'd0);
        chk("spur_result", rsp_result, 80'd0);

        // Single-requester vectors
        vt[0] = '{0, 5'd0,  2'd0, ONE, TWO, 2, 1'b0, THREE};
        vt[1] = '{1, 5'd3,  2'd2, 80'h1234_5678_9ABC_DEF0_1111, 80'hFEDC_BA98_7654_3210_2222, 1, 1'b1, '0};
        vt[2] = '{2, 5'd7,  2'd1, 80'hC000_8000_0000_0000_0001, 80'h0000_0000_0000_0000_FFFF, 0, 1'b0, '0};
        vt[3] = '{0, 5'd1,  2'd3, 80'hAAAA_5555_AAAA_5555_AAAA, 80'h5555_AAAA_5555_AAAA_5555, 5, 1'b0, '0};
        vt[4] = '{2, 5'd12, 2'd0, 80'h7FFF_FFFF_FFFF_FFFF_FFFF, 80'h8000_0000_0000_0000_0000, 1, 1'b1, '0};
        vt[5] = '{1, 5'd31, 2'd1, 80'h0001_0002_0003_0004_0005, 80'h4003_A000_0000_0000_0000, 3, 1'b0, '0};
        for (int i = 1; i < 6; i++) vt[i].exp = unit_fn(vt[i].op, vt[i].rnd, vt[i].a, vt[i].b);

        for (int i = 0; i < 6; i++) begin
            stub_delay = vt[i].dly;
            set_req(vt[i].idx, vt[i].op, vt[i].rnd, vt[i].a, vt[i].b);
            chk("vec_idle_grant", 80'(grant), 80'd0);
            @(negedge clk);
            chk("vec_grant", 80'(grant), 80'(oh(vt[i].idx)));
            chk("vec_enable", 80'(arith_enable), 80'd1);
            chk("vec_arith_a", arith_a, vt[i].a);
            chk("vec_arith_b", arith_b, vt[i].b);
            chk("vec_arith_op", 80'(arith_op), 80'(vt[i].op));
            chk("vec_arith_rnd", 80'(arith_rounding), 80'(vt[i].rnd));
            if (vt[i].drop_early) req_valid[vt[i].idx] = 1'b0;
            wait_done(k, 50);
            chk("vec_latency", 80'(k), 80'(vt[i].dly + 2));
            chk("vec_rsp_done", 80'(rsp_done), 80'(oh(vt[i].idx)));
            chk("vec_result", rsp_result, vt[i].exp);
            chk("vec_enable_dropped", 80'(arith_enable), 80'd0);
            req_valid[vt[i].idx] = 1'b0;
            @(negedge clk);
            chk("vec_pulse_once", 80'(rsp_done), 80'd0);
            chk("vec_grant_cleared", 80'(grant), 80'd0);
            chk("vec_result_held", rsp_result, vt[i].exp);
        end

        // Two requesters asserted together and held for six operations
        do_reset();
        rand_req(0);
        rand_req(1);
        rem[0] = 3; rem[1] = 3; rem[2] = 0;
        model_order();
        @(negedge clk);
        chk("both_first_grant", 80'(grant), 80'(oh(0)));
        run_ops(200);
        check_order("rr_two");
        for (int i = 0; i < 6; i++)
            chk("rr_alternate", (i < got_q.size()) ? 80'(got_q[i]) : '1, 80'(i % 2));

        // All requesters continuously busy, starting from the pointer left above
        rand_req(0);
        rand_req(1);
        rand_req(2);
        rem[0] = 2; rem[1] = 2; rem[2] = 2;
        model_order();
        run_ops(300);
        check_order("rr_three");

        // Request arriving in the arith_done cycle waits for IDLE
        stub_delay = 3;
        rand_req(0);
        k = 0;
        while (arith_done !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("late_done_seen", 80'(arith_done), 80'd1);
        rand_req(1);
        @(negedge clk);
        chk("late_rsp0", 80'(rsp_done), 80'(oh(0)));
        chk("late_rsp0_result", rsp_result, unit_fn(cur_op[0], cur_rnd[0], cur_a[0], cur_b[0]));
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("late_idle_gap", 80'(grant), 80'd0);
        @(negedge clk);
        chk("late_grant1", 80'(grant), 80'(oh(1)));
        wait_done(k, 50);
        chk("late_rsp1", 80'(rsp_done), 80'(oh(1)));
        chk("late_rsp1_result", rsp_result, unit_fn(cur_op[1], cur_rnd[1], cur_a[1], cur_b[1]));
        req_valid[1] = 1'b0;
        @(negedge clk);

        // Reset in BUSY: immediate abort, no response, pointer back to 0
        stub_mute = 1'b1;
        rand_req(0);
        @(negedge clk);
        chk("abort_busy_before", 80'(arith_enable), 80'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_enable", 80'(arith_enable), 80'd0);
        chk("abort_grant", 80'(grant), 80'd0);
        chk("abort_rsp_done", 80'(rsp_done), 80'd0);
        chk("abort_busy", 80'(busy), 80'd0);
        req_valid = '0;
        @(negedge clk);
        chk("abort_no_rsp", 80'(rsp_done), 80'd0);
        @(negedge clk);
        reset     = 1'b0;
        stub_mute = 1'b0;
        rand_req(1);
        rand_req(2);
        rem[0] = 0; rem[1] = 1; rem[2] = 1;
        mptr = 0;
        model_order();
        @(negedge clk);
        chk("abort_ptr0_grant", 80'(grant), 80'(oh(1)));
        run_ops(100);
        check_order("abort_after");

        // Unit that never answers
        stub_mute = 1'b1;
        rand_req(2);
        @(negedge clk);
        chk("to_enable", 80'(arith_enable), 80'd1);
        wait_done(k, 80);
`ifdef FPU_ARB_TIMEOUT_EN
        chk("to_latency", 80'(k), 80'(TO + 1));
        chk("to_rsp_done", 80'(rsp_done), 80'(oh(2)));
        chk("to_result_qnan", rsp_result, 80'hFFFF_C000_0000_0000_0000);
        chk("to_err_set", 80'(timeout_err), 80'd1);
        req_valid[2] = 1'b0;
        stub_mute    = 1'b0;
        repeat (3) @(negedge clk);
        chk("to_err_sticky", 80'(timeout_err), 80'd1);
        do_reset();
        chk("to_err_reset", 80'(timeout_err), 80'd0);
`else
        chk("no_to_waits", 80'(k), 80'd80);
        chk("no_to_busy", 80'(busy), 80'd1);
        chk("no_to_err", 80'(timeout_err), 80'd0);
        req_valid[2] = 1'b0;
        stub_mute    = 1'b0;
        do_reset();
`endif

        // Randomised rounds against the ordering model
        for (int r = 0; r < 10; r++) begin
            int mask;
            mask = $urandom_range(1, (1 << N) - 1);
            for (int i = 0; i < N; i++) begin
                rem[i] = mask[i] ? $urandom_range(1, 3) : 0;
                if (mask[i]) rand_req(i);
            end
            stub_delay = $urandom_range(0, 4);
            model_order();
            run_ops(400);
            check_order("rand_order");
        end

        chk("grant_onehot", 80'(multi_grant), 80'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
